bmp_blitter: RTL

Parametrised pixel blitter that copies bitmap images or font glyphs from external synchronous ROMs into the frame buffer (videoMem) at a given screen location. It sits between the CPU-mapped control registers and the videoMem write port. It supports N image ROMs, transparency, and removal. It clips at the screen edges and streams one pixel per clock with no row-wrap bubbles.

---
 rtl/bmp_blitter_if.sv | 42 ++++
 rtl/bmp_blitter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bmp_blitter_if.sv
// Command, ROM and videoMem signals of the bitmap blitter.
// slave = blitter side, master = controller / memory side.
interface bmp_blitter_if #(
    parameter int SCR_W  = 640,
    parameter int SCR_H  = 480,
    parameter int PIX_W  = 9,
    parameter int N_IMG  = 4,
    parameter int IMG_AW = 16,
    parameter int FNT_AW = 14
);
    localparam int WA = $clog2(SCR_W * SCR_H);
    localparam int IW = (N_IMG > 1) ? $clog2(N_IMG) : 1;

    logic                   start;
    logic [1:0]             mode;
    logic [IW-1:0]          img_idx;
    logic [5:0]             glyph_idx;
    logic [9:0]             xloc;
    logic [8:0]             yloc;
    logic [PIX_W-1:0]       fill_color;
    logic                   busy;
    logic                   done;
    logic [IMG_AW-1:0]      img_addr;
    logic [N_IMG*PIX_W-1:0] img_data;
    logic [FNT_AW-1:0]      fnt_addr;
    logic [PIX_W-1:0]       fnt_data;
    logic [WA-1:0]          waddr;
    logic [PIX_W-1:0]       wdata;
    logic                   we;

    modport slave (
        input  start, mode, img_idx, glyph_idx, xloc, yloc,
        input  fill_color, img_data, fnt_data,
        output busy, done, img_addr, fnt_addr, waddr, wdata, we
    );

    modport master (
        output start, mode, img_idx, glyph_idx, xloc, yloc,
        output fill_color, img_data, fnt_data,
        input  busy, done, img_addr, fnt_addr, waddr, wdata, we
    );
endinterface

// File: rtl/bmp_blitter.sv
// Pixel blitter: image ROMs / font glyphs into videoMem, one pixel per clock.
// Define BLIT_FILL_EN to enable mode 11 (fill the image footprint).
module bmp_blitter #(
    parameter int SCR_W     = 640,
    parameter int SCR_H     = 480,
    parameter int PIX_W     = 9,
    parameter int N_IMG     = 4,
    parameter int IMG_AW    = 16,
    parameter int FNT_AW    = 14,
    parameter int FNT_W     = 13,
    parameter int FNT_H     = 16,
    parameter int FNT_PITCH = 544,
    parameter logic [PIX_W-1:0] TRANSP = 9'h088
) (
    input logic          clk,
    input logic          rst_n,
    bmp_blitter_if.slave bus
);
    localparam int WA = $clog2(SCR_W * SCR_H);
    localparam int IW = (N_IMG > 1) ? $clog2(N_IMG) : 1;
`ifdef BLIT_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_W, S_HDR_H, S_DRAW, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [PIX_W-1:0]  fill_q, fill_d;
    logic [PIX_W-1:0]  w_q, w_d, h_q, h_d;
    logic [PIX_W-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic [FNT_AW-1:0] rb_q, rb_d;
    logic [IMG_AW-1:0] p_q, p_d;
    logic              we_q, we_d, done_q, done_d;
    logic [WA-1:0]     waddr_q, waddr_d;
    logic [PIX_W-1:0]  wdata_q, wdata_d;

    logic [PIX_W-1:0]  img_px, src, pix;
    logic              img_ok, glyph, last_col, hit;
    logic [31:0]       sx, sy;
    logic [FNT_AW-1:0] gbase, nxt, fnt_addr_c;
    logic [IMG_AW-1:0] img_addr_c;

    always_comb begin
        img_px = '0;
        img_ok = 1'b0;
        for (int k = 0; k < N_IMG; k++) begin
            if (idx_q == IW'(k)) begin
                img_px = bus.img_data[k*PIX_W +: PIX_W];
                img_ok = 1'b1;
            end
        end
    end

    assign glyph = (mode_q == 2'b10);
    assign src   = glyph ? bus.fnt_data : img_px;
    assign gbase = FNT_AW'(bus.glyph_idx) * FNT_AW'(FNT_W);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        fill_d  = fill_q;
        w_d     = w_q;
        h_d     = h_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        rb_d    = rb_q;
        p_d     = p_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        sx      = 32'(x_q) + 32'(cx_q);
        sy      = 32'(y_q) + 32'(cy_q);
        last_col   = (cx_q == w_q - 1'b1);
        nxt        = last_col ? rb_q + FNT_AW'(FNT_PITCH)
                              : rb_q + FNT_AW'(cx_q) + 1'b1;
        hit        = 1'b0;
        pix        = '0;
        img_addr_c = '0;
        fnt_addr_c = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    idx_d  = bus.img_idx;
                    x_d    = bus.xloc;
                    y_d    = bus.yloc;
                    fill_d = bus.fill_color;
                    cx_d   = '0;
                    cy_d   = '0;
                    p_d    = '0;
                    rb_d   = gbase;
                    unique case (bus.mode)
                        2'b10: begin
                            // glyph geometry is fixed, so skip the header
                            fnt_addr_c = gbase;
                            w_d        = PIX_W'(FNT_W);
                            h_d        = PIX_W'(FNT_H);
                            state_d    = S_DRAW;
                        end
                        2'b11: begin
                            if (FILL_EN) state_d = S_HDR_W;
                            else         done_d  = 1'b1;
                        end
                        default: state_d = S_HDR_W;
                    endcase
                end
            end
            S_HDR_W: begin
                img_addr_c = IMG_AW'(1);
                w_d        = img_px;
                state_d    = S_HDR_H;
            end
            S_HDR_H: begin
                img_addr_c = IMG_AW'(2);
                h_d        = img_px;
                state_d    = (w_q == '0 || img_px == '0) ? S_DONE : S_DRAW;
            end
            S_DRAW: begin
                // fetch the next pixel while the current one is written
                img_addr_c = p_q + IMG_AW'(3);
                fnt_addr_c = nxt;
                unique case (mode_q)
                    2'b01: begin
                        hit = (src != TRANSP);
                        pix = '0;
                    end
                    2'b11: begin
                        hit = 1'b1;
                        pix = fill_q;
                    end
                    default: begin
                        hit = (src != TRANSP);
                        pix = src;
                    end
                endcase
                if (sx < 32'(SCR_W) && sy < 32'(SCR_H)
                    && (glyph || img_ok) && hit) begin
                    we_d    = 1'b1;
                    waddr_d = WA'(sy * 32'(SCR_W) + sx);
                    wdata_d = pix;
                end
                p_d = p_q + 1'b1;
                if (last_col) begin
                    cx_d = '0;
                    cy_d = cy_q + 1'b1;
                    rb_d = rb_q + FNT_AW'(FNT_PITCH);
                    if (cy_q == h_q - 1'b1) state_d = S_DONE;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fill_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            rb_q    <= '0;
            p_q     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fill_q  <= fill_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rb_q    <= rb_d;
            p_q     <= p_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.img_addr = img_addr_c;
    assign bus.fnt_addr = fnt_addr_c;
endmodule
